// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        RESP      = 2'd3
    } arb_state_t;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    localparam int unsigned PHYS_ADDR_W = 21;
    typedef logic [PHYS_ADDR_W-1:0] phys_memory_address_t;

endpackage

// File: rtl/core_memory_arbiter_rr_pick.sv
// Combinational requester picker: round-robin from base+1, or fixed lowest-index priority.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned N    = 2,
    parameter int unsigned MODE = ARB_RR,
    localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] base_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int unsigned    start;
    int unsigned    hit;
    logic           found;

    // Rotate the request vector so the search always starts at bit 0.
    always_comb begin
        start = (MODE == ARB_FIXED) ? 32'd0 : ((32'(base_i) + 32'd1) % N);
        dbl   = {req_i, req_i};
        rot   = N'(dbl >> start);
        hit   = 32'd0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                hit   = i;
            end
        end
        any_o = found;
        idx_o = IW'((start + hit) % N);
        gnt_o = found ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/core_memory_arbiter.sv
// N-port arbiter onto one shared memory bus: one transaction in flight,
// per-owner response routing and a response-timeout watchdog.
module core_memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned ADDR_W         = PHYS_ADDR_W,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned ARB_MODE       = ARB_RR,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_PORTS-1:0]                          req_valid,
    output logic [NUM_PORTS-1:0]                          req_ready,
    input  logic [NUM_PORTS-1:0]                          req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]                   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]                   req_wdata,
    output logic [NUM_PORTS-1:0]                          rsp_valid,
    output logic [DATA_W-1:0]                             rsp_rdata,
    output logic                                          mem_req_valid,
    input  logic                                          mem_req_ready,
    output logic                                          mem_req_write,
    output logic [ADDR_W-1:0]                             mem_req_addr,
    output logic [DATA_W-1:0]                             mem_req_wdata,
    input  logic                                          mem_rsp_valid,
    input  logic [DATA_W-1:0]                             mem_rsp_rdata,
    output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant_id,
    output logic                                          timeout_err
);

    localparam int unsigned IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    arb_state_t           state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 write_q, write_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 mem_req_valid_q, mem_req_valid_d;
    logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [CW-1:0]        wd_cnt_q, wd_cnt_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_PORTS-1:0] pick_gnt;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 sel_write;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [NUM_PORTS-1:0] owner_oh;
    logic                 wd_expired;

    rr_pick #(
        .N    (NUM_PORTS),
        .MODE (ARB_MODE)
    ) u_pick (
        .req_i  (req_valid),
        .base_i (rr_ptr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Payload mux of the winning port, driven by the one-hot grant.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (pick_gnt[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready is gated by reset so the bus looks idle while reset is held.
    assign req_ready  = (state_q == IDLE && !reset) ? pick_gnt : '0;
    assign owner_oh   = NUM_PORTS'(1) << owner_q;
    assign wd_expired = (TIMEOUT_CYCLES != 0) && ((32'(wd_cnt_q) + 32'd1) == TIMEOUT_CYCLES);

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_ptr_d        = rr_ptr_q;
        write_d         = write_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        mem_req_valid_d = mem_req_valid_q;
        rsp_valid_d     = '0;
        rsp_rdata_d     = rsp_rdata_q;
        wd_cnt_d        = wd_cnt_q;
        timeout_d       = timeout_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d         = ISSUE;
                    owner_d         = pick_idx;
                    rr_ptr_d        = pick_idx;
                    write_d         = sel_write;
                    addr_d          = sel_addr;
                    wdata_d         = sel_wdata;
                    mem_req_valid_d = 1'b1;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    if (write_q) begin
                        state_d     = RESP;
                        rsp_valid_d = owner_oh;
                        rsp_rdata_d = '0;
                    end else if (mem_rsp_valid) begin
                        state_d     = RESP;
                        rsp_valid_d = owner_oh;
                        rsp_rdata_d = mem_rsp_rdata;
                    end else begin
                        state_d  = WAIT_RESP;
                        wd_cnt_d = '0;
                    end
                end
            end
            WAIT_RESP: begin
                if (mem_rsp_valid) begin
                    state_d     = RESP;
                    rsp_valid_d = owner_oh;
                    rsp_rdata_d = mem_rsp_rdata;
                end else if (wd_expired) begin
                    state_d     = RESP;
                    rsp_valid_d = owner_oh;
                    rsp_rdata_d = '1;
                    timeout_d   = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            owner_q         <= '0;
            rr_ptr_q        <= IW'(NUM_PORTS - 1);
            write_q         <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            mem_req_valid_q <= 1'b0;
            rsp_valid_q     <= '0;
            rsp_rdata_q     <= '0;
            wd_cnt_q        <= '0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            rr_ptr_q        <= rr_ptr_d;
            write_q         <= write_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            mem_req_valid_q <= mem_req_valid_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            wd_cnt_q        <= wd_cnt_d;
            timeout_q       <= timeout_d;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_write = write_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign grant_id      = owner_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_core_memory_arbiter.sv
// Directed bench: a 3-port round-robin instance and a 2-port fixed-priority instance.
module tb_core_memory_arbiter;

    localparam int unsigned AW = 21;
    localparam int unsigned DW = 64;

    logic clk;
    logic reset;

    // 3-port round-robin DUT, watchdog at 8 cycles
    logic [2:0]      r_req_valid, r_req_ready, r_req_write, r_rsp_valid;
    logic [3*AW-1:0] r_req_addr;
    logic [3*DW-1:0] r_req_wdata;
    logic [DW-1:0]   r_rsp_rdata, r_mem_req_wdata, r_mem_rsp_rdata;
    logic            r_mem_req_valid, r_mem_req_ready, r_mem_req_write, r_mem_rsp_valid;
    logic [AW-1:0]   r_mem_req_addr;
    logic [1:0]      r_grant_id;
    logic            r_timeout_err;

    // 2-port fixed-priority DUT
    logic [1:0]      f_req_valid, f_req_ready, f_req_write, f_rsp_valid;
    logic [2*AW-1:0] f_req_addr;
    logic [2*DW-1:0] f_req_wdata;
    logic [DW-1:0]   f_rsp_rdata, f_mem_req_wdata, f_mem_rsp_rdata;
    logic            f_mem_req_valid, f_mem_req_ready, f_mem_req_write, f_mem_rsp_valid;
    logic [AW-1:0]   f_mem_req_addr;
    logic [0:0]      f_grant_id;
    logic            f_timeout_err;

    int errors = 0;
    int checks = 0;

    core_memory_arbiter #(
        .NUM_PORTS(3), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT_CYCLES(8)
    ) dut_rr (
        .clk(clk), .reset(reset),
        .req_valid(r_req_valid), .req_ready(r_req_ready), .req_write(r_req_write),
        .req_addr(r_req_addr), .req_wdata(r_req_wdata),
        .rsp_valid(r_rsp_valid), .rsp_rdata(r_rsp_rdata),
        .mem_req_valid(r_mem_req_valid), .mem_req_ready(r_mem_req_ready),
        .mem_req_write(r_mem_req_write), .mem_req_addr(r_mem_req_addr),
        .mem_req_wdata(r_mem_req_wdata),
        .mem_rsp_valid(r_mem_rsp_valid), .mem_rsp_rdata(r_mem_rsp_rdata),
        .grant_id(r_grant_id), .timeout_err(r_timeout_err)
    );

    core_memory_arbiter #(
        .NUM_PORTS(2), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT_CYCLES(8)
    ) dut_fx (
        .clk(clk), .reset(reset),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata),
        .mem_req_valid(f_mem_req_valid), .mem_req_ready(f_mem_req_ready),
        .mem_req_write(f_mem_req_write), .mem_req_addr(f_mem_req_addr),
        .mem_req_wdata(f_mem_req_wdata),
        .mem_rsp_valid(f_mem_rsp_valid), .mem_rsp_rdata(f_mem_rsp_rdata),
        .grant_id(f_grant_id), .timeout_err(f_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        r_req_valid = '0; f_req_valid = '0;
        r_mem_req_ready = 1'b0; r_mem_rsp_valid = 1'b0;
        f_mem_req_ready = 1'b0; f_mem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        r_req_valid = 3'b111;
        f_req_valid = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (r_req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready: got %b expected 000", r_req_ready); end
        checks++; if (r_mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b expected 0", r_mem_req_valid); end
        checks++; if (r_rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 000", r_rsp_valid); end
        checks++; if (r_rsp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", r_rsp_rdata); end
        checks++; if (r_grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", r_grant_id); end
        checks++; if (r_timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", r_timeout_err); end
        checks++; if (r_mem_req_addr !== 21'd0) begin errors++; $display("FAIL reset_mem_req_addr: got %h expected 0", r_mem_req_addr); end
        checks++; if (f_req_ready !== 2'b00) begin errors++; $display("FAIL reset_fx_req_ready: got %b expected 00", f_req_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (r_req_ready !== 3'b001) begin errors++; $display("FAIL first_accept_rr: got %b expected 001", r_req_ready); end
        checks++; if (f_req_ready !== 2'b01) begin errors++; $display("FAIL first_accept_fx: got %b expected 01", f_req_ready); end
        r_req_valid = '0;
        f_req_valid = '0;
    endtask

    task automatic test_rr_order();
        int n;
        int bad;
        int idx;
        int gnt[6];
        int cyc[6];
        int expv[6] = '{0, 1, 2, 0, 1, 2};
        do_reset();
        r_req_valid = 3'b111; r_req_write = 3'b000;
        r_mem_req_ready = 1'b1; r_mem_rsp_valid = 1'b1; r_mem_rsp_rdata = 64'h1111;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (r_req_ready != 3'b000) begin
                case (r_req_ready)
                    3'b001:  idx = 0;
                    3'b010:  idx = 1;
                    3'b100:  idx = 2;
                    default: idx = 7;
                endcase
                gnt[n] = idx;
                cyc[n] = c;
                n++;
            end
            @(posedge clk); #1;
        end
        r_req_valid = '0;
        checks++; if (n !== 6) begin errors++; $display("FAIL rr_grant_count: got %0d expected 6", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (gnt[i] !== expv[i]) begin errors++; $display("FAIL rr_grant_order[%0d]: got %0d expected %0d", i, gnt[i], expv[i]); end
        end
        bad = 0;
        for (int i = 1; i < n; i++) if (cyc[i] - cyc[i-1] != 3) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL rr_back_to_back_gap: got %0d wrong gaps expected 0", bad); end
    endtask

    task automatic test_fixed_priority();
        int n;
        int idx;
        int gnt[5];
        int expv[5] = '{0, 0, 0, 0, 1};
        do_reset();
        f_req_valid = 2'b11; f_req_write = 2'b00;
        f_mem_req_ready = 1'b1; f_mem_rsp_valid = 1'b1; f_mem_rsp_rdata = 64'h2222;
        n = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clk);
            if (f_req_ready != 2'b00) begin
                case (f_req_ready)
                    2'b01:   idx = 0;
                    2'b10:   idx = 1;
                    default: idx = 7;
                endcase
                gnt[n] = idx;
                n++;
            end
            @(posedge clk); #1;
            if (n >= 4) f_req_valid = 2'b10;
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL fx_grant_count: got %0d expected 5", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (gnt[i] !== expv[i]) begin errors++; $display("FAIL fx_grant_order[%0d]: got %0d expected %0d", i, gnt[i], expv[i]); end
        end
        checks++; if (f_grant_id !== 1'b1) begin errors++; $display("FAIL fx_grant_id: got %0d expected 1", f_grant_id); end
        f_req_valid = '0;
    endtask

    task automatic test_read_late();
        int bad;
        do_reset();
        r_req_valid = 3'b010; r_req_write = 3'b000;
        r_req_addr = '0; r_req_addr[AW +: AW] = 21'h1F000;
        r_mem_req_ready = 1'b1; r_mem_rsp_valid = 1'b0; r_mem_rsp_rdata = '0;
        @(negedge clk);
        checks++; if (r_req_ready !== 3'b010) begin errors++; $display("FAIL read_accept: got %b expected 010", r_req_ready); end
        @(posedge clk); #1;
        r_req_valid = '0;
        @(negedge clk);
        checks++; if (r_mem_req_valid !== 1'b1) begin errors++; $display("FAIL read_mem_req_valid: got %b expected 1", r_mem_req_valid); end
        checks++; if (r_mem_req_addr !== 21'h1F000) begin errors++; $display("FAIL read_mem_req_addr: got %h expected 1f000", r_mem_req_addr); end
        checks++; if (r_mem_req_write !== 1'b0) begin errors++; $display("FAIL read_mem_req_write: got %b expected 0", r_mem_req_write); end
        checks++; if (r_grant_id !== 2'd1) begin errors++; $display("FAIL read_grant_id: got %0d expected 1", r_grant_id); end
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (r_rsp_valid !== 3'b000 || r_mem_req_valid !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL read_wait_quiet: got %0d bad cycles expected 0", bad); end
        @(posedge clk); #1;
        r_mem_rsp_valid = 1'b1; r_mem_rsp_rdata = 64'hDEADBEEF_CAFEF00D;
        @(posedge clk); #1;
        r_mem_rsp_valid = 1'b0; r_mem_rsp_rdata = '0;
        @(negedge clk);
        checks++; if (r_rsp_valid !== 3'b010) begin errors++; $display("FAIL read_rsp_valid: got %b expected 010", r_rsp_valid); end
        checks++; if (r_rsp_rdata !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL read_rsp_rdata: got %h expected deadbeefcafef00d", r_rsp_rdata); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (r_rsp_valid !== 3'b000) begin errors++; $display("FAIL read_rsp_single_pulse: got %b expected 000", r_rsp_valid); end
    endtask

    task automatic test_write_stall();
        int bad;
        @(posedge clk); #1;
        r_req_valid = 3'b100; r_req_write = 3'b100;
        r_req_addr[2*AW +: AW] = 21'h0ABCD;
        r_req_wdata = '0; r_req_wdata[2*DW +: DW] = 64'h0123_4567_89AB_CDEF;
        r_mem_req_ready = 1'b0;
        @(negedge clk);
        checks++; if (r_req_ready !== 3'b100) begin errors++; $display("FAIL write_accept: got %b expected 100", r_req_ready); end
        @(posedge clk); #1;
        r_req_valid = '0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (r_mem_req_valid !== 1'b1 || r_mem_req_write !== 1'b1 || r_mem_req_addr !== 21'h0ABCD ||
                r_mem_req_wdata !== 64'h0123_4567_89AB_CDEF || r_rsp_valid !== 3'b000) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL write_stall_stable: got %0d bad cycles expected 0", bad); end
        r_mem_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (r_mem_req_valid !== 1'b1) begin errors++; $display("FAIL write_valid_before_ready: got %b expected 1", r_mem_req_valid); end
        @(posedge clk); #1;
        r_mem_req_ready = 1'b0;
        @(negedge clk);
        checks++; if (r_rsp_valid !== 3'b100) begin errors++; $display("FAIL write_rsp_valid: got %b expected 100", r_rsp_valid); end
        checks++; if (r_rsp_rdata !== 64'd0) begin errors++; $display("FAIL write_rsp_rdata: got %h expected 0", r_rsp_rdata); end
        checks++; if (r_mem_req_valid !== 1'b0) begin errors++; $display("FAIL write_mem_req_drop: got %b expected 0", r_mem_req_valid); end
        checks++; if (r_grant_id !== 2'd2) begin errors++; $display("FAIL write_grant_id: got %0d expected 2", r_grant_id); end
    endtask

    task automatic test_timeout();
        int bad;
        @(posedge clk); #1;
        r_req_valid = 3'b001; r_req_write = 3'b000;
        r_req_addr[0 +: AW] = 21'h00123;
        r_mem_req_ready = 1'b1; r_mem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (r_req_ready !== 3'b001) begin errors++; $display("FAIL to_accept: got %b expected 001", r_req_ready); end
        @(posedge clk); #1;
        r_req_valid = '0;
        bad = 0;
        repeat (9) begin
            @(negedge clk);
            if (r_timeout_err !== 1'b0 || r_rsp_valid !== 3'b000) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL to_early: got %0d bad cycles expected 0", bad); end
        @(negedge clk);
        checks++; if (r_rsp_valid !== 3'b001) begin errors++; $display("FAIL to_rsp_valid: got %b expected 001", r_rsp_valid); end
        checks++; if (r_rsp_rdata !== {DW{1'b1}}) begin errors++; $display("FAIL to_rsp_rdata: got %h expected all ones", r_rsp_rdata); end
        checks++; if (r_timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b expected 1", r_timeout_err); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (r_timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b expected 1", r_timeout_err); end
        @(posedge clk); #1;
        r_req_valid = 3'b010;
        @(negedge clk);
        checks++; if (r_req_ready !== 3'b010) begin errors++; $display("FAIL rst_accept: got %b expected 010", r_req_ready); end
        @(posedge clk); #1;
        r_req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++; if (r_timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err_cleared: got %b expected 0", r_timeout_err); end
        checks++; if (r_rsp_valid !== 3'b000) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 000", r_rsp_valid); end
        checks++; if (r_grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: got %0d expected 0", r_grant_id); end
        checks++; if (r_rsp_rdata !== 64'd0) begin errors++; $display("FAIL rst_rsp_rdata: got %h expected 0", r_rsp_rdata); end
        @(posedge clk); #1;
        reset = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (r_rsp_valid !== 3'b000 || r_mem_req_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rst_dropped_op: got %0d bad cycles expected 0", bad); end
        r_mem_req_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        r_req_valid = '0; r_req_write = '0; r_req_addr = '0; r_req_wdata = '0;
        r_mem_req_ready = 1'b0; r_mem_rsp_valid = 1'b0; r_mem_rsp_rdata = '0;
        f_req_valid = '0; f_req_write = '0; f_req_addr = '0; f_req_wdata = '0;
        f_mem_req_ready = 1'b0; f_mem_rsp_valid = 1'b0; f_mem_rsp_rdata = '0;

        test_reset();
        test_rr_order();
        test_fixed_priority();
        test_read_late();
        test_write_stall();
        test_timeout();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
